mem_stage_banked: RTL and testbench

Parametrised memory-access pipeline stage with MEM/WB register for the in-house processor. It provides a byte-addressed data memory split into NUM_BANKS banks, selected by `cuadrante`. Loads and stores are 1..MAX_BYTES bytes wide, little-endian, and wrap inside the bank. It adds WB stall/flush control, bank-range error reporting and an independent registered pixel read port for the video path.

---
 rtl/mem_stage_banked.sv | 124 ++++++++++++
 tb/tb_mem_stage_banked.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_banked.sv
// Memory-access pipeline stage: banked byte-addressed data memory, MEM/WB register with
// stall/flush and bank-range error, plus an independent registered pixel read port.
module mem_stage_banked #(
    parameter int DATA_W    = 19,
    parameter int NUM_BANKS = 16,
    parameter int BANK_W    = 4,
    parameter int ADDR_W    = 8,
    parameter int MAX_BYTES = 2,
    parameter int SIZE_W    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BANK_W-1:0] cuadrante,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RDM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [SIZE_W-1:0] SizeM,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              pixel_en,
    input  logic [BANK_W-1:0] pixel_bank,
    input  logic [ADDR_W-1:0] pixel_addr,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RdW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUResultW,
    output logic              BankErrW,
    output logic [7:0]        pixel,
    output logic              pixel_valid
);
    localparam int BankBytes = 2 ** ADDR_W;
    localparam int MemBytes  = NUM_BANKS * BankBytes;
    localparam int IdxW      = (MemBytes > 1) ? $clog2(MemBytes) : 1;
    localparam int AccW      = 8 * MAX_BYTES;

    // Flat storage: bank-major, so {bank, addr} is the byte index for any valid bank.
    logic [7:0] mem [MemBytes];

    logic                 bank_ok;
    logic                 pix_ok;
    logic                 store_en;
    int                   access_len;
    logic [MAX_BYTES-1:0] byte_en;
    logic [IdxW-1:0]      byte_idx [MAX_BYTES];
    logic [IdxW-1:0]      pix_idx;
    logic [AccW-1:0]      wdata;
    logic [AccW-1:0]      rdata;
    logic                 unused_wdata;

    assign unused_wdata = ^WriteDataM;

    always_comb begin
        bank_ok    = int'(cuadrante) < NUM_BANKS;
        pix_ok     = int'(pixel_bank) < NUM_BANKS;
        pix_idx    = IdxW'({pixel_bank, pixel_addr});
        access_len = (int'(SizeM) + 1 > MAX_BYTES) ? MAX_BYTES : int'(SizeM) + 1;
        store_en   = MemWriteM && !StallW && !FlushW && bank_ok && !reset;
        wdata      = AccW'(WriteDataM);
        rdata      = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            byte_en[i]  = i < access_len;
            // Address add is ADDR_W wide so the access wraps inside the bank.
            byte_idx[i] = IdxW'({cuadrante, ALUResultM[ADDR_W-1:0] + ADDR_W'(i)});
            if (bank_ok && byte_en[i]) begin
                rdata[8*i +: 8] = mem[byte_idx[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (byte_en[i]) begin
                    mem[byte_idx[i]] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RdW        <= '0;
            ReadDataW  <= '0;
            ALUResultW <= '0;
            BankErrW   <= 1'b0;
        end else if (!StallW) begin
            if (FlushW) begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= 1'b0;
                RdW        <= '0;
                ReadDataW  <= '0;
                ALUResultW <= '0;
                BankErrW   <= 1'b0;
            end else begin
                RegWriteW  <= RegWriteM;
                ResultSrcW <= ResultSrcM;
                RdW        <= RDM;
                ReadDataW  <= DATA_W'(rdata);
                ALUResultW <= ALUResultM;
                BankErrW   <= !bank_ok;
            end
        end
    end

    // Pixel read samples pre-edge memory, so a same-edge store is not visible yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= pixel_en;
            if (pixel_en) begin
                pixel <= pix_ok ? mem[pix_idx] : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_banked.sv
// Directed bench for mem_stage_banked (8 banks) with a bank/byte-array reference model.
module tb_mem_stage_banked;
    localparam int DW   = 19;
    localparam int NB   = 8;
    localparam int MAXB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    cuadrante;
    logic          RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]    RDM;
    logic [DW-1:0] WriteDataM, ALUResultM;
    logic          SizeM;
    logic          StallW, FlushW;
    logic          pixel_en;
    logic [3:0]    pixel_bank;
    logic [7:0]    pixel_addr;
    logic          RegWriteW, ResultSrcW, BankErrW, pixel_valid;
    logic [4:0]    RdW;
    logic [DW-1:0] ReadDataW, ALUResultW;
    logic [7:0]    pixel;

    int nvec = 0;
    int nerr = 0;

    mem_stage_banked #(
        .DATA_W(DW), .NUM_BANKS(NB), .BANK_W(4), .ADDR_W(8), .MAX_BYTES(MAXB), .SIZE_W(1)
    ) dut (
        .clk(clk), .reset(reset), .cuadrante(cuadrante), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RDM(RDM), .WriteDataM(WriteDataM),
        .ALUResultM(ALUResultM), .SizeM(SizeM), .StallW(StallW), .FlushW(FlushW),
        .pixel_en(pixel_en), .pixel_bank(pixel_bank), .pixel_addr(pixel_addr),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .BankErrW(BankErrW), .pixel(pixel), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    // Reference model: 2-D byte array plus a "written" flag so unwritten bytes are not judged.
    logic [7:0]    mm [NB][256];
    bit            kn [NB][256];
    logic          e_rw, e_rs, e_err, e_pv, e_datak, e_pixk;
    logic [4:0]    e_rd;
    logic [DW-1:0] e_data, e_alu;
    logic [7:0]    e_pix;

    function automatic int alen(input logic sz);
        return (int'(sz) + 1 > MAXB) ? MAXB : int'(sz) + 1;
    endfunction

    function automatic logic [DW-1:0] mload(input logic [2:0] b, input logic [7:0] a, input int n);
        logic [DW-1:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (DW'(mm[b][8'(int'(a) + i)]) << (8 * i));
        return v;
    endfunction

    function automatic bit mknown(input logic [2:0] b, input logic [7:0] a, input int n);
        bit k = 1'b1;
        for (int i = 0; i < n; i++) k = k & kn[b][8'(int'(a) + i)];
        return k;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rw <= 0; e_rs <= 0; e_rd <= 0; e_data <= 0; e_alu <= 0; e_err <= 0;
            e_pix <= 0; e_pv <= 0; e_datak <= 1; e_pixk <= 1;
        end else begin
            if (!StallW) begin
                if (FlushW) begin
                    e_rw <= 0; e_rs <= 0; e_rd <= 0; e_data <= 0; e_alu <= 0; e_err <= 0;
                    e_datak <= 1;
                end else begin
                    e_rw    <= RegWriteM;
                    e_rs    <= ResultSrcM;
                    e_rd    <= RDM;
                    e_alu   <= ALUResultM;
                    e_err   <= cuadrante >= NB;
                    e_data  <= (cuadrante < NB) ?
                               mload(cuadrante[2:0], ALUResultM[7:0], alen(SizeM)) : '0;
                    e_datak <= (cuadrante >= NB) ||
                               mknown(cuadrante[2:0], ALUResultM[7:0], alen(SizeM));
                    if (MemWriteM && cuadrante < NB) begin
                        for (int i = 0; i < alen(SizeM); i++) begin
                            mm[cuadrante[2:0]][8'(int'(ALUResultM[7:0]) + i)] <=
                                WriteDataM[8*i +: 8];
                            kn[cuadrante[2:0]][8'(int'(ALUResultM[7:0]) + i)] <= 1'b1;
                        end
                    end
                end
            end
            e_pv <= pixel_en;
            if (pixel_en) begin
                if (pixel_bank < NB) begin
                    e_pix  <= mm[pixel_bank[2:0]][pixel_addr];
                    e_pixk <= kn[pixel_bank[2:0]][pixel_addr];
                end else begin
                    e_pix  <= 8'h00;
                    e_pixk <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
        chk("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
        chk("RdW", 32'(RdW), 32'(e_rd));
        chk("ALUResultW", 32'(ALUResultW), 32'(e_alu));
        chk("BankErrW", 32'(BankErrW), 32'(e_err));
        chk("pixel_valid", 32'(pixel_valid), 32'(e_pv));
        if (e_datak) chk("ReadDataW", 32'(ReadDataW), 32'(e_data));
        if (e_pixk) chk("pixel", 32'(pixel), 32'(e_pix));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic mop(input logic [3:0] bk, input logic we, input logic [7:0] a,
                       input logic [DW-1:0] d, input logic sz);
        cuadrante  = bk;
        MemWriteM  = we;
        ALUResultM = {7'h00, bk, a};
        WriteDataM = d;
        SizeM      = sz;
        RegWriteM  = 1'b1;
        ResultSrcM = !we;
        RDM        = a[4:0];
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " RegWriteW"}, 32'(RegWriteW), 0);
        chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 0);
        chk({tag, " RdW"}, 32'(RdW), 0);
        chk({tag, " ReadDataW"}, 32'(ReadDataW), 0);
        chk({tag, " ALUResultW"}, 32'(ALUResultW), 0);
        chk({tag, " BankErrW"}, 32'(BankErrW), 0);
        chk({tag, " pixel"}, 32'(pixel), 0);
        chk({tag, " pixel_valid"}, 32'(pixel_valid), 0);
    endtask

    initial begin
        reset = 1'b0; cuadrante = 0; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RDM = 0;
        WriteDataM = 0; ALUResultM = 0; SizeM = 0; StallW = 0; FlushW = 0;
        pixel_en = 0; pixel_bank = 0; pixel_addr = 0;
        #1 reset = 1'b1;
        #1 chk_all_zero("por");
        @(negedge clk);
        cmp_model();
        reset = 1'b0;

        // Seed bytes whose survival is checked later.
        mop(4'd2, 1, 8'd0, 19'h11, 0);
        mop(4'd7, 1, 8'd6, 19'h99, 0);
        mop(4'd2, 1, 8'd5, 19'h3C, 0);

        // Overlapping little-endian stores and loads.
        mop(4'd2, 1, 8'd6, 19'h0EEFF, 1);
        mop(4'd2, 1, 8'd7, 19'h0CCAA, 1);
        mop(4'd2, 0, 8'd6, 19'h0, 1);      chk("ld6 after 2 stores", 32'(ReadDataW), 32'h0AAFF);
        mop(4'd2, 0, 8'd8, 19'h0, 0);      chk("ld8 byte", 32'(ReadDataW), 32'hCC);
        mop(4'd2, 1, 8'd6, 19'h000BB, 0);
        mop(4'd2, 0, 8'd6, 19'h0, 1);      chk("ld6 after byte st", 32'(ReadDataW), 32'hAABB);
        mop(4'd2, 1, 8'd7, 19'h2, 0);
        mop(4'd2, 0, 8'd6, 19'h0, 1);      chk("ld6 after st7", 32'(ReadDataW), 32'h02BB);

        // Wrap inside bank 3.
        mop(4'd3, 1, 8'd255, 19'h1234, 1);
        mop(4'd3, 0, 8'd0, 19'h0, 0);      chk("wrap ld0", 32'(ReadDataW), 32'h12);
        mop(4'd3, 0, 8'd255, 19'h0, 0);    chk("wrap ld255", 32'(ReadDataW), 32'h34);
        mop(4'd2, 0, 8'd0, 19'h0, 0);      chk("bank2 byte0", 32'(ReadDataW), 32'h11);

        // Stall holds W and blocks the store.
        mop(4'd2, 1, 8'd10, 19'h0102, 1);
        mop(4'd2, 0, 8'd10, 19'h0, 1);     chk("ld10", 32'(ReadDataW), 32'h0102);
        StallW = 1;
        mop(4'd2, 1, 8'd10, 19'h5566, 1);
        chk("stall ReadDataW", 32'(ReadDataW), 32'h0102);
        chk("stall RdW", 32'(RdW), 32'd10);
        StallW = 0;
        mop(4'd2, 0, 8'd10, 19'h0, 1);     chk("ld10 after stall", 32'(ReadDataW), 32'h0102);

        // Flush inserts a bubble and blocks the store.
        FlushW = 1;
        mop(4'd2, 1, 8'd5, 19'h77, 0);
        chk("flush RegWriteW", 32'(RegWriteW), 0);
        chk("flush RdW", 32'(RdW), 0);
        FlushW = 0;
        mop(4'd2, 0, 8'd5, 19'h0, 0);      chk("ld5 after flush", 32'(ReadDataW), 32'h3C);

        // Out-of-range bank.
        mop(4'd15, 1, 8'd6, 19'h4242, 1);
        chk("badbank st err", 32'(BankErrW), 1);
        chk("badbank st data", 32'(ReadDataW), 0);
        mop(4'd15, 0, 8'd6, 19'h0, 1);     chk("badbank ld data", 32'(ReadDataW), 0);
        mop(4'd7, 0, 8'd6, 19'h0, 0);      chk("bank7 intact", 32'(ReadDataW), 32'h99);
        chk("bank7 err", 32'(BankErrW), 0);
        mop(4'd2, 0, 8'd6, 19'h0, 0);      chk("bank2 intact", 32'(ReadDataW), 32'hBB);

        // Pixel port: read-before-write, hold, invalid bank.
        pixel_en = 1; pixel_bank = 4'd2; pixel_addr = 8'd6;
        mop(4'd2, 1, 8'd6, 19'h77, 0);
        chk("pixel old", 32'(pixel), 32'hBB);
        chk("pixel_valid on", 32'(pixel_valid), 1);
        mop(4'd2, 0, 8'd7, 19'h0, 0);      chk("pixel new", 32'(pixel), 32'h77);
        pixel_en = 0;
        mop(4'd2, 0, 8'd7, 19'h0, 0);
        chk("pixel hold", 32'(pixel), 32'h77);
        chk("pixel_valid off", 32'(pixel_valid), 0);
        pixel_en = 1; pixel_bank = 4'd12;
        tick();                             chk("pixel badbank", 32'(pixel), 0);
        pixel_en = 0;

        // Mid-run reset clears outputs at once; memory survives.
        mop(4'd2, 0, 8'd6, 19'h0, 1);      chk("ld6 pre-reset", 32'(ReadDataW), 32'h0277);
        #2 reset = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        cmp_model();
        reset = 1'b0;
        mop(4'd2, 0, 8'd6, 19'h0, 1);      chk("ld6 post-reset", 32'(ReadDataW), 32'h0277);
        mop(4'd3, 0, 8'd255, 19'h0, 1);    chk("wrap post-reset", 32'(ReadDataW), 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
